// File: rtl/adc_capture.sv
// Frame capture buffer: streams ADC samples into a RAM, pulses start_o and freezes it for the consumer.
// Optional macro ADC_CAPTURE_PAD_EN replicates the last sample into PAD tail entries before start_o.
module adc_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int LEN    = 1000,
    parameter int PAD    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       arm_i,
    input  logic                       release_i,
    input  logic                       adc_valid_i,
    input  logic [DATA_W-1:0]          adc_data_i,
    output logic                       adc_ready_o,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       start_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overrun_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LAST_C = (AW+1)'(LEN - 1);

    if (LEN < 1 || LEN + PAD > DEPTH) begin : g_bad_cfg
        $error("adc_capture: LEN/PAD do not fit in DEPTH");
    end

`ifdef ADC_CAPTURE_PAD_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_PAD     = 2'd2,
        S_HOLD    = 2'd3
    } state_t;
    localparam logic [AW-1:0] LEN_A   = AW'(LEN);
    localparam logic [AW-1:0] PADL_A  = AW'(PAD - 1);
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd3
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [AW:0]         count_q, count_d;
    logic                overrun_q, overrun_d;
    logic                start_q, start_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DATA_W-1:0]   wr_data;

`ifdef ADC_CAPTURE_PAD_EN
    logic [AW-1:0]       pad_cnt_q, pad_cnt_d;
    logic [DATA_W-1:0]   last_q, last_d;
`endif

    assign adc_ready_o = (state_q == S_CAPTURE);
`ifdef ADC_CAPTURE_PAD_EN
    assign busy_o      = (state_q == S_CAPTURE) || (state_q == S_PAD);
`else
    assign busy_o      = (state_q == S_CAPTURE);
`endif
    assign start_o     = start_q;
    assign count_o     = count_q;
    assign overrun_o   = overrun_q;
    assign rd_data_o   = rd_data_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        wr_en     = 1'b0;
        wr_addr   = count_q[AW-1:0];
        wr_data   = adc_data_i;
`ifdef ADC_CAPTURE_PAD_EN
        pad_cnt_d = pad_cnt_q;
        last_d    = last_q;
`endif

        if (adc_valid_i && !adc_ready_o) begin
            overrun_d = 1'b1;
        end

        // arm restarts the frame from any state and drops a sample offered alongside it
        if (arm_i) begin
            state_d   = S_CAPTURE;
            count_d   = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_CAPTURE: begin
                    if (adc_valid_i) begin
                        wr_en   = 1'b1;
                        count_d = count_q + (AW+1)'(1);
`ifdef ADC_CAPTURE_PAD_EN
                        last_d  = adc_data_i;
                        if (count_q == LAST_C) begin
                            pad_cnt_d = '0;
                            state_d   = (PAD == 0) ? S_HOLD : S_PAD;
                        end
`else
                        if (count_q == LAST_C) begin
                            state_d = S_HOLD;
                        end
`endif
                    end
                end
`ifdef ADC_CAPTURE_PAD_EN
                S_PAD: begin
                    wr_en   = 1'b1;
                    wr_addr = LEN_A + pad_cnt_q;
                    wr_data = last_q;
                    if (pad_cnt_q == PADL_A) begin
                        state_d = S_HOLD;
                    end else begin
                        pad_cnt_d = pad_cnt_q + AW'(1);
                    end
                end
`endif
                S_HOLD: begin
                    if (release_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        start_d = (state_d == S_HOLD) && (state_q != S_HOLD);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            overrun_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            start_q   <= start_d;
        end
    end

`ifdef ADC_CAPTURE_PAD_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pad_cnt_q <= '0;
        end else begin
            pad_cnt_q <= pad_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        last_q <= last_d;
    end
`endif

    // RAM contents survive reset; a same-cycle read of the written address sees the old word
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture with LEN=8, DEPTH=16, PAD=4; pad checks follow ADC_CAPTURE_PAD_EN.
module tb_adc_capture;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LEN    = 8;
    localparam int PAD    = 4;
    localparam int AW     = $clog2(DEPTH);
`ifdef ADC_CAPTURE_PAD_EN
    localparam int PADC = PAD;
`else
    localparam int PADC = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              arm = 1'b0;
    logic              rel = 1'b0;
    logic              adc_valid = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              adc_ready;
    logic [AW-1:0]     rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              start;
    logic              busy;
    logic [AW:0]       count;
    logic              overrun;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int s0;

    adc_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN(LEN), .PAD(PAD)) dut (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .release_i(rel),
        .adc_valid_i(adc_valid), .adc_data_i(adc_data), .adc_ready_o(adc_ready),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .start_o(start), .busy_o(busy),
        .count_o(count), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start) start_cnt <= start_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=stuck expected=finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        adc_valid = 1'b1;
        adc_data  = d;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic finish_frame();
        for (int k = 0; k < PADC; k++) begin
            chk("pad_no_start", start, 0);
            chk("pad_busy", busy, 1);
            tick();
        end
        chk("start_pulse", start, 1);
        chk("hold_busy", busy, 0);
        tick();
        chk("start_one_cycle", start, 0);
    endtask

    task automatic rd(input int a, input logic [7:0] exp, input string tag);
        rd_addr = AW'(a);
        tick();
        chk(tag, rd_data, exp);
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_ready", adc_ready, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        tick();

        // continuous frame 10..17
        pulse_arm();
        chk("arm_ready", adc_ready, 1);
        chk("arm_busy", busy, 1);
        s0 = start_cnt;
        for (int i = 0; i < LEN; i++) send(8'(10 + i));
        chk("frame1_count", count, LEN);
        chk("frame1_ready_off", adc_ready, 0);
        finish_frame();
        chk("frame1_starts", start_cnt - s0, 1);
        for (int a = 0; a < LEN; a++) rd(a, 8'(10 + a), "frame1_rd");
`ifdef ADC_CAPTURE_PAD_EN
        for (int a = LEN; a < LEN + PAD; a++) rd(a, 8'd17, "pad_rd");
`endif
        chk("frame1_overrun", overrun, 0);

        // release keeps count
        rel = 1'b1;
        tick();
        rel = 1'b0;
        chk("release_busy", busy, 0);
        chk("release_count", count, LEN);

        // overrun in IDLE
        rd_addr = '0;
        send(8'hEE);
        chk("ovr_flag", overrun, 1);
        chk("ovr_ready", adc_ready, 0);
        tick();
        chk("ovr_ram0", rd_data, 8'd10);
        pulse_arm();
        chk("ovr_cleared", overrun, 0);
        chk("rearm_count", count, 0);

        // gapped stream A0..A7
        s0 = start_cnt;
        for (int i = 0; i < 2 * LEN - 1; i++) begin
            adc_valid = (i % 2 == 0);
            adc_data  = (i % 2 == 0) ? 8'(8'hA0 + i / 2) : 8'hFF;
            tick();
        end
        adc_valid = 1'b0;
        chk("gap_count", count, LEN);
        finish_frame();
        chk("gap_starts", start_cnt - s0, 1);
        for (int a = 0; a < LEN; a++) rd(a, 8'(8'hA0 + a), "gap_rd");

        // re-arm mid-frame, sample with arm dropped
        s0 = start_cnt;
        pulse_arm();
        for (int i = 0; i < 3; i++) send(8'(8'h30 + i));
        chk("partial_count", count, 3);
        arm = 1'b1;
        adc_valid = 1'b1;
        adc_data = 8'h55;
        tick();
        arm = 1'b0;
        adc_valid = 1'b0;
        chk("rearm_mid_count", count, 0);
        chk("rearm_mid_ready", adc_ready, 1);
        for (int i = 0; i < LEN; i++) send(8'(8'h60 + i));
        finish_frame();
        chk("rearm_starts", start_cnt - s0, 1);
        for (int a = 0; a < LEN; a++) rd(a, 8'(8'h60 + a), "rearm_rd");

        // arm beats release in HOLD
        arm = 1'b1;
        rel = 1'b1;
        tick();
        arm = 1'b0;
        rel = 1'b0;
        chk("arm_wins", adc_ready, 1);

        // reset mid-capture
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) send(8'(8'h70 + i));
        chk("mid_count", count, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", adc_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_start", start, 0);
        chk("midrst_count", count, 0);
        chk("midrst_rd", rd_data, 0);
        rd(0, 8'h70, "midrst_keep0");
        rd(5, 8'h65, "midrst_keep5");
        chk("midrst_no_start", start_cnt - s0, 0);

        // read/write collision returns old data
        pulse_arm();
        rd_addr = '0;
        send(8'h99);
        chk("rdw_old", rd_data, 8'h70);
        tick();
        chk("rdw_new", rd_data, 8'h99);
        chk("rdw_count", count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_capture.md
# adc_capture

Front-end sample buffer feeding the smoothing filter. Accepts 8-bit ADC samples over a valid/ready stream, writes one frame of `LEN` samples into an internal RAM, then pulses `start` and freezes the buffer while the filter reads it through a registered random-access port. The buffer is released back to capture by `release` or by a fresh `arm`.

## Interface
- `DATA_W`, 8: sample width.
- `DEPTH`, 1024: buffer entries; address width `AW = $clog2(DEPTH)`.
- `LEN`, 1000: samples per frame; `LEN + PAD <= DEPTH`, `LEN >= 1`.
- `PAD`, 4: tail pad entries, only used with `ADC_CAPTURE_PAD_EN`; equals filter size minus 1.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `arm` in 1: single-cycle request to start a new frame.
- `release` in 1: consumer done with frame; return to IDLE.
- `adc_valid` in 1: sample present.
- `adc_data` in DATA_W: sample value.
- `adc_ready` out 1: block accepts a sample this cycle.
- `rd_addr` in AW: consumer read address.
- `rd_data` out DATA_W: `mem[rd_addr]`, one cycle latency.
- `start` out 1: one-cycle pulse, frame ready.
- `busy` out 1: high in CAPTURE or PAD.
- `count` out AW+1: samples accepted in current frame.
- `overrun` out 1: sticky; sample offered while not capturing.

## Operation
- States: IDLE, CAPTURE, PAD (only with macro), HOLD.
- IDLE: `adc_ready=0`. `arm` -> CAPTURE, `count<=0`, `overrun<=0`.
- CAPTURE: `adc_ready=1`. On `adc_valid & adc_ready`: `mem[count]<=adc_data`, `count<=count+1`. Handshake with `count==LEN-1` -> PAD (macro) or HOLD; `count` ends at LEN.
- PAD: `adc_ready=0`; writes last accepted sample to `mem[LEN..LEN+PAD-1]`, one entry per cycle, then HOLD.
- HOLD: `adc_ready=0`; memory not written. `start=1` only on the first HOLD cycle. `release` -> IDLE (`count` held). `arm` -> CAPTURE as from IDLE.
- `arm` in CAPTURE or PAD: restart frame, `count<=0`, pad aborted, no `start`. Sample handshaked in the same cycle as `arm` is discarded.
- `arm` and `release` together: `arm` wins.
- `adc_valid` high while `adc_ready=0` (IDLE, PAD, HOLD): `overrun<=1`; cleared only by `arm` or `rst`.
- Read port independent of state: `rd_data<=mem[rd_addr]` every cycle. Read and write to same address in same cycle returns old data.
- Addresses `>= LEN` (`>= LEN+PAD` with macro) return stale contents.

## Timing
- Reset: state IDLE; `adc_ready`, `start`, `busy`, `overrun`, `rd_data`, `count` all 0. RAM not cleared.
- `arm` at cycle t -> `adc_ready=1` at t+1.
- Final handshake at cycle t: without macro, `start=1` at t+1; with macro, PAD writes at t+1..t+PAD, `start=1` at t+PAD+1.
- `count` updates the cycle after each handshake.
- `rst` mid-frame: IDLE next cycle, no `start`, partial data stays in RAM.
- `rd_data` valid one cycle after `rd_addr`.

## Configuration
- `ADC_CAPTURE_PAD_EN` defined: PAD state compiled in; entries `LEN..LEN+PAD-1` hold copy of sample `LEN-1`, so filter windows crossing the frame end read defined data; `start` delayed by PAD cycles.
- Not defined: no PAD state, `PAD` ignored; HOLD entered directly after the last sample.

## Test plan
- LEN=8, no macro: `arm`, stream 1..8 continuously -> `start` pulse one cycle after 8th handshake, `count=8`, reads of addr 0..7 return 1..8 with 1-cycle latency.
- LEN=8, PAD=4, macro on: stream 10..17 -> addr 8..11 read 17, `start` 5 cycles after last handshake, `busy` high through PAD.
- Backpressure/gaps: `adc_valid` toggled every other cycle, values 0xA0..0xA7 -> all 8 stored in order, single `start`.
- Overrun: `adc_valid=1` in IDLE before `arm` -> `overrun=1`, `adc_ready=0`, RAM addr 0 unchanged; next `arm` clears `overrun`.
- Re-arm mid-frame: 3 samples then `arm` with valid sample 0x55 -> 0x55 dropped, `count=0`, next 8 samples form frame, one `start`.
- `rst` during CAPTURE after 5 samples -> next cycle all outputs 0, IDLE, no `start`; `release` in HOLD -> IDLE, `count` holds LEN.
